reg_file_mp_sb: RTL and testbench

//  Multi-port eBPF register file for the IDU, with per-register busy scoreboard and write-to-read bypass.
//  - NUM_RD read ports and NUM_WR write ports, e.g. EXU writeback plus LSU load return.
//  - Scoreboard lets the IDU stall consumers of in-flight long-latency results.
//  - Frame pointer register FP_IDX (r10) is read-only and resets to FP_INIT.

---
 rtl/reg_file_mp_sb_pkg.sv | 11 +
 rtl/reg_file_scoreboard.sv | 55 +++++
 rtl/reg_file_mp_sb.sv | 111 +++++++++++
 tb/tb_reg_file_mp_sb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_sb_pkg.sv
// Shared constants for the eBPF register file: depth, address width and the
// read-only frame-pointer register.
package reg_file_mp_sb_pkg;

  localparam int          XLEN                = 32;
  localparam int          REG_FILE_DEPTH      = 11;
  localparam int          REG_FILE_ADDR_WIDTH = $clog2(REG_FILE_DEPTH);
  localparam int          FP_IDX              = 10;
  localparam logic [31:0] FP_INIT             = 32'h8000_0000;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits marking registers whose producer is still in flight,
// with set/clear/flush update and NUM_RD combinational lookup ports.
module reg_file_scoreboard
  import reg_file_mp_sb_pkg::*;
#(
  parameter int DEPTH  = REG_FILE_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2,
  parameter int FP_IDX = reg_file_mp_sb_pkg::FP_IDX
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     flush,
  input  logic [DEPTH-1:0]         clr,
  input  logic [NUM_RD-1:0]        lu_en,
  input  logic [NUM_RD*ADDR_W-1:0] lu_addr,
  output logic [NUM_RD-1:0]        lu_busy
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path through the block can infer a latch.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (clr[i]) busy_d[i] = 1'b0;
      // A set arriving with the retiring write means a newer producer owns it.
      if (set_en && i != FP_IDX && set_addr == ADDR_W'(i)) busy_d[i] = 1'b1;
    end
    if (flush) busy_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    lu_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (lu_en[r]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (lu_addr[r*ADDR_W +: ADDR_W] == ADDR_W'(i)) lu_busy[r] = busy_q[i];
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_mp_sb.sv
// Multi-port eBPF register file with busy scoreboard, write-to-read bypass and
// a read-only frame pointer.
module reg_file_mp_sb
  import reg_file_mp_sb_pkg::*;
#(
  parameter int          DATA_W  = XLEN,
  parameter int          DEPTH   = REG_FILE_DEPTH,
  parameter int          ADDR_W  = $clog2(DEPTH),
  parameter int          NUM_RD  = 2,
  parameter int          NUM_WR  = 2,
  parameter int          FP_IDX  = reg_file_mp_sb_pkg::FP_IDX,
  parameter logic [31:0] FP_INIT = reg_file_mp_sb_pkg::FP_INIT,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  input  logic                     sb_flush,
  output logic                     fp_wr_err
);

  logic [DATA_W-1:0] regs   [DEPTH];
  logic [DATA_W-1:0] wr_val [DEPTH];
  logic [DEPTH-1:0]  wr_hit;
  logic              fp_hit;
  logic [NUM_RD-1:0] rd_byp;
  logic [NUM_RD-1:0] lu_busy;

  // Per-register winning write; ascending port order lets the higher port
  // override. FP and out-of-range addresses never produce a hit.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_val[i] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (i != FP_IDX && wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
          wr_hit[i] = 1'b1;
          wr_val[i] = wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    fp_hit = sb_set_en && sb_set_addr == ADDR_W'(FP_IDX);
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(FP_IDX)) fp_hit = 1'b1;
    end
  end

  // NOTE: the storage is a bank of individual flops, not an SRAM, so every
  // entry is reset; FP must come up at FP_INIT without any software write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= (i == FP_IDX) ? DATA_W'(FP_INIT) : '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) regs[i] <= wr_val[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fp_wr_err <= 1'b0;
    else       fp_wr_err <= fp_hit;
  end

  always_comb begin
    rd_data = '0;
    rd_byp  = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_en[r]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_addr[r*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
            rd_byp[r] = BYPASS && wr_hit[i];
            rd_data[r*DATA_W +: DATA_W] = (BYPASS && wr_hit[i]) ? wr_val[i] : regs[i];
          end
        end
      end
    end
  end

  // A bypassed read already carries the producer's result, so it is not busy.
  assign rd_busy = lu_busy & ~rd_byp;

  reg_file_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .FP_IDX (FP_IDX)
  ) u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .set_en   (sb_set_en),
    .set_addr (sb_set_addr),
    .flush    (sb_flush),
    .clr      (wr_hit),
    .lu_en    (rd_en),
    .lu_addr  (rd_addr),
    .lu_busy  (lu_busy)
  );

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Self-checking bench for reg_file_mp_sb: directed scenarios plus randomized
// traffic against an array-based model of the architectural state.
module tb_reg_file_mp_sb;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 11;
  localparam int FP = 10;
  localparam logic [31:0] FP_VAL = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NR-1:0]   rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic [NW-1:0]   wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic            sb_set_en;
  logic [AW-1:0]   sb_set_addr;
  logic            sb_flush;
  logic            fp_wr_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_reg  [DEPTH];
  bit          m_busy [DEPTH];
  bit          m_fp;

  always #5 clk = ~clk;

  reg_file_mp_sb dut (
    .clk         (clk),
    .rstn        (rstn),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_flush    (sb_flush),
    .fp_wr_err   (fp_wr_err)
  );

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = (i == FP) ? FP_VAL : 32'h0;
      m_busy[i] = 1'b0;
    end
    m_fp = 1'b0;
  endfunction

  // Winning same-cycle write for an address, highest port first.
  function automatic bit model_wr_hit(input int a, output logic [31:0] d);
    d = '0;
    if (a == FP || a >= DEPTH) return 1'b0;
    for (int w = NW - 1; w >= 0; w--) begin
      if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
        d = wr_data[w*DW +: DW];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_data(input int r);
    int a;
    logic [31:0] d;
    a = int'(rd_addr[r*AW +: AW]);
    if (!rd_en[r] || a >= DEPTH) return 32'h0;
    if (model_wr_hit(a, d)) return d;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input int r);
    int a;
    logic [31:0] d;
    a = int'(rd_addr[r*AW +: AW]);
    if (!rd_en[r] || a >= DEPTH) return 1'b0;
    if (model_wr_hit(a, d)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic void idle();
    rd_en = '0; rd_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; sb_flush = 1'b0;
  endfunction

  // Advance one clock edge and apply the architectural effect of the inputs.
  task automatic tick();
    logic [31:0] nreg [DEPTH];
    bit          nbusy [DEPTH];
    bit          nfp;
    int          a;
    nreg = m_reg; nbusy = m_busy; nfp = 1'b0;
    for (int w = 0; w < NW; w++) begin
      a = int'(wr_addr[w*AW +: AW]);
      if (wr_en[w]) begin
        if (a == FP) nfp = 1'b1;
        else if (a < DEPTH) begin
          nreg[a]  = wr_data[w*DW +: DW];
          nbusy[a] = 1'b0;
        end
      end
    end
    a = int'(sb_set_addr);
    if (sb_set_en) begin
      if (a == FP) nfp = 1'b1;
      else if (a < DEPTH) nbusy[a] = 1'b1;
    end
    if (sb_flush) for (int i = 0; i < DEPTH; i++) nbusy[i] = 1'b0;
    @(posedge clk);
    m_reg = nreg; m_busy = nbusy; m_fp = nfp;
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 6; k++) begin
      idle();
      wr_en = 2'b11;
      wr_addr = {4'(k % 10), 4'((k + 3) % 10)};
      wr_data = {$urandom, $urandom};
      sb_set_en = 1'b1; sb_set_addr = 4'(k);
      tick();
    end
    wr_en = 2'b11; wr_addr = {4'd7, 4'd10};
    #2 rstn = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      rd_en = 2'b11; rd_addr = {4'(i), 4'(i)};
      #1;
      n_cmp++;
      if (rd_data[31:0] !== ((i == FP) ? FP_VAL : 32'h0)) begin
        n_fail++; $display("FAIL reset_data r%0d: got %h exp %h", i, rd_data[31:0], (i == FP) ? FP_VAL : 32'h0);
      end
      n_cmp++;
      if (rd_busy !== 2'b00 || fp_wr_err !== 1'b0) begin
        n_fail++; $display("FAIL reset_flags r%0d: got busy=%b err=%b exp 00/0", i, rd_busy, fp_wr_err);
      end
    end
    idle();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_collision();
    idle();
    wr_en = 2'b11; wr_addr = {4'd3, 4'd3}; wr_data = {32'hBBBB_0002, 32'hAAAA_0001};
    rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'hBBBB_0002) begin
      n_fail++; $display("FAIL collision_bypass: got %h exp %h", rd_data[31:0], 32'hBBBB_0002);
    end
    tick();
    idle();
    rd_en = 2'b10; rd_addr = {4'd3, 4'd0};
    #1;
    n_cmp++;
    if (rd_data[63:32] !== 32'hBBBB_0002 || rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL collision_stored: got %h exp %h", rd_data, {32'hBBBB_0002, 32'h0});
    end
  endtask

  task automatic test_fp_protect();
    idle();
    wr_en = 2'b01; wr_addr = {4'd0, 4'd10}; wr_data = {32'h0, 32'h0000_1234};
    rd_en = 2'b01; rd_addr = {4'd0, 4'd10};
    #1;
    n_cmp++;
    if (rd_data[31:0] !== FP_VAL || fp_wr_err !== 1'b0) begin
      n_fail++; $display("FAIL fp_same_cycle: got %h err=%b exp %h err=0", rd_data[31:0], fp_wr_err, FP_VAL);
    end
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {4'd0, 4'd10};
    #1;
    n_cmp++;
    if (rd_data[31:0] !== FP_VAL || fp_wr_err !== 1'b1) begin
      n_fail++; $display("FAIL fp_after: got %h err=%b exp %h err=1", rd_data[31:0], fp_wr_err, FP_VAL);
    end
    tick();
    n_cmp++;
    if (fp_wr_err !== 1'b0) begin
      n_fail++; $display("FAIL fp_pulse_width: got err=%b exp 0", fp_wr_err);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    sb_set_en = 1'b1; sb_set_addr = 4'd5;
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
    #1;
    n_cmp++;
    if (rd_busy !== 2'b01) begin
      n_fail++; $display("FAIL sb_busy_set: got %b exp 01", rd_busy);
    end
    wr_en = 2'b10; wr_addr = {4'd5, 4'd0}; wr_data = {32'h0000_0055, 32'h0};
    #1;
    n_cmp++;
    if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h55) begin
      n_fail++; $display("FAIL sb_bypass: got busy=%b data=%h exp 00/00000055", rd_busy, rd_data[31:0]);
    end
    tick();
    idle();
    rd_en = 2'b10; rd_addr = {4'd5, 4'd0};
    #1;
    n_cmp++;
    if (rd_busy !== 2'b00 || rd_data[63:32] !== 32'h55) begin
      n_fail++; $display("FAIL sb_cleared: got busy=%b data=%h exp 00/00000055", rd_busy, rd_data[63:32]);
    end
  endtask

  task automatic test_set_clear_race();
    idle();
    sb_set_en = 1'b1; sb_set_addr = 4'd2;
    wr_en = 2'b10; wr_addr = {4'd2, 4'd0}; wr_data = {32'hABCD_0123, 32'h0};
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {4'd0, 4'd2};
    #1;
    n_cmp++;
    if (rd_busy !== 2'b01 || rd_data[31:0] !== 32'hABCD_0123) begin
      n_fail++; $display("FAIL race: got busy=%b data=%h exp 01/abcd0123", rd_busy, rd_data[31:0]);
    end
  endtask

  task automatic test_flush();
    idle(); sb_set_en = 1'b1; sb_set_addr = 4'd1; tick();
    idle(); sb_set_en = 1'b1; sb_set_addr = 4'd4; tick();
    idle();
    rd_en = 2'b11; rd_addr = {4'd4, 4'd1};
    #1;
    n_cmp++;
    if (rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL flush_pre: got %b exp 11", rd_busy);
    end
    sb_flush = 1'b1; sb_set_en = 1'b1; sb_set_addr = 4'd6;
    tick();
    idle();
    rd_en = 2'b11; rd_addr = {4'd4, 4'd1};
    #1;
    n_cmp++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL flush_post: got %b exp 00", rd_busy);
    end
    rd_en = 2'b01; rd_addr = {4'd6, 4'd6};
    #1;
    n_cmp++;
    if (rd_busy !== 2'b00 || rd_data[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL flush_set_r6: got busy=%b data1=%h exp 00/0", rd_busy, rd_data[63:32]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      idle();
      for (int r = 0; r < NR; r++) begin
        rd_en[r] = ($urandom_range(0, 7) != 0);
        rd_addr[r*AW +: AW] = 4'($urandom_range(0, 12));
      end
      for (int w = 0; w < NW; w++) begin
        wr_en[w] = ($urandom_range(0, 2) == 0);
        wr_addr[w*AW +: AW] = 4'($urandom_range(0, 12));
        wr_data[w*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) wr_addr[AW +: AW] = wr_addr[0 +: AW];
      sb_set_en = ($urandom_range(0, 2) == 0);
      sb_set_addr = 4'($urandom_range(0, 12));
      sb_flush = ($urandom_range(0, 19) == 0);
      #1;
      for (int r = 0; r < NR; r++) begin
        n_cmp++;
        if (rd_data[r*DW +: DW] !== exp_data(r) || rd_busy[r] !== exp_busy(r)) begin
          n_fail++;
          $display("FAIL random_read cyc%0d port%0d: got %h/%b exp %h/%b", k, r,
                   rd_data[r*DW +: DW], rd_busy[r], exp_data(r), exp_busy(r));
        end
      end
      tick();
      n_cmp++;
      if (fp_wr_err !== m_fp) begin
        n_fail++; $display("FAIL random_fp_err cyc%0d: got %b exp %b", k, fp_wr_err, m_fp);
      end
    end
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    test_reset();
    test_collision();
    test_fp_protect();
    test_scoreboard();
    test_set_clear_race();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
